// File: rtl/imem_loader.sv
// imem_loader: instruction-side front end for the 8-bit single-cycle CPU.
//   LOAD mode: operator keys instructions on Switch and commits them with a
//              debounced Load_Btn press into a small instruction store.
//   RUN mode:  Instruction is fetched from the store at PC and the CPU is
//              released from reset.
// Ports:
//   Clk          system clock, rising edge
//   Reset        synchronous, active-low reset
//   Switch[7:0]  instruction value keyed by the operator
//   Load_Btn     commit button (raw, asynchronous)
//   Clear_Btn    erase-program button (raw, asynchronous)
//   Run_Sw       mode switch, 1 = RUN (raw, asynchronous)
//   PC[7:0]      program counter from the CPU
//   Instruction  registered instruction to the CPU
//   Cpu_Reset    active-high CPU hold; 1 in LOAD, 0 in RUN
//   Load_Count   number of instructions stored
//   Full         Load_Count == DEPTH
//   Running      FSM is in RUN

// Input conditioner: 2-flop synchronizer followed by a level debouncer.
module imem_loader_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive synchronized samples that disagree with the level;
    // any agreeing sample restarts the run.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
endmodule

module imem_loader #(
    parameter int unsigned ADDR_W          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [7:0]  FILL            = 8'h00
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [7:0]      Switch,
    input  logic            Load_Btn,
    input  logic            Clear_Btn,
    input  logic            Run_Sw,
    input  logic [7:0]      PC,
    output logic [7:0]      Instruction,
    output logic            Cpu_Reset,
    output logic [ADDR_W:0] Load_Count,
    output logic            Full,
    output logic            Running
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned CMP_W = (CNT_W > 8) ? CNT_W : 8;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       instr_q, instr_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             running_q, running_d;
    logic             full_q, full_d;
    logic             mem_we;
    logic [7:0]       mem_q [DEPTH];

    logic load_lvl, clear_lvl, run_lvl;
    logic load_dly_q, clear_dly_q;
    logic load_pulse_c, clear_pulse_c;

    imem_loader_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_load (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .raw_i  (Load_Btn),
        .level_o(load_lvl)
    );

    imem_loader_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_clear (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .raw_i  (Clear_Btn),
        .level_o(clear_lvl)
    );

    imem_loader_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_run (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .raw_i  (Run_Sw),
        .level_o(run_lvl)
    );

    // One-cycle rising-edge pulses from the debounced button levels.
    assign load_pulse_c  = load_lvl  & ~load_dly_q;
    assign clear_pulse_c = clear_lvl & ~clear_dly_q;

    // Next state, store write and registered-output values.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        instr_d = FILL;
        mem_we  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                // Mode change wins over any button pulse in the same cycle;
                // clear wins over load.
                if (run_lvl && (count_q != '0)) begin
                    state_d = ST_RUN;
                end else if (clear_pulse_c) begin
                    count_d = '0;
                end else if (load_pulse_c && !full_q) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!run_lvl) begin
                    state_d = ST_LOAD;
                end else if (CMP_W'(PC) < CMP_W'(count_q)) begin
                    // Full-width compare so PC values above DEPTH never alias.
                    instr_d = mem_q[PC[ADDR_W-1:0]];
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        cpu_reset_d = (state_d == ST_LOAD);
        running_d   = (state_d == ST_RUN);
        full_d      = (count_d == FULL_CNT);
    end

    // State, count and status registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= ST_LOAD;
            count_q     <= '0;
            instr_q     <= FILL;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            full_q      <= 1'b0;
            load_dly_q  <= 1'b0;
            clear_dly_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            instr_q     <= instr_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
            full_q      <= full_d;
            load_dly_q  <= load_lvl;
            clear_dly_q <= clear_lvl;
        end
    end

    // Instruction store; contents survive reset and are gated by count_q.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[count_q[ADDR_W-1:0]] <= Switch;
        end
    end

    assign Instruction = instr_q;
    assign Cpu_Reset   = cpu_reset_q;
    assign Load_Count  = count_q;
    assign Full        = full_q;
    assign Running     = running_q;
endmodule
